// File: rtl/led_fader.sv
// led_fader: fade/ramp sequencer in front of the led PWM peripheral.
//
// Each of three channels has a target brightness (TGT), a current duty (CUR)
// and shares a STEP size and a tick divider (DIV). On every prescaler tick,
// every channel whose CUR differs from TGT moves toward it by STEP without
// overshooting (STEP = 0 jumps straight to TGT). Every changed duty is
// forwarded to the led block as a single-cycle write to address 0, 4 or 8,
// one write per cycle, chosen round-robin among the pending channels.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   rd_en, addr      CPU read strobe and register byte address
//   rd_data/rd_valid registered read response, one cycle after rd_en
//   wr_en, wr_data   CPU write strobe and data (uses addr)
//   led_wr_en        single-cycle write strobe to led
//   led_addr         led register address (0, 4 or 8)
//   led_wr_data      duty value written to led
//
// Register map: 0/4/8 TGT0..2, 12 STEP, 16 DIV_LO, 20 DIV_HI (low DIV_W-8
// bits stored), 24 STATUS (bit i = CUR[i] != TGT[i]), 28/29/30 CUR0..2.
module led_fader #(
  parameter int unsigned DIV_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_en,
  input  logic [4:0] addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       led_wr_en,
  output logic [4:0] led_addr,
  output logic [7:0] led_wr_data
);

  localparam int unsigned HI_W = DIV_W - 8;

  // Round-robin pointer: the channel searched first by the writer.
  typedef enum logic [1:0] {
    RR_CH0 = 2'd0,
    RR_CH1 = 2'd1,
    RR_CH2 = 2'd2
  } rr_e;

  // CPU-visible configuration
  logic [7:0]       tgt_q [3];
  logic [7:0]       tgt_d [3];
  logic [7:0]       step_q, step_d;
  logic [7:0]       div_lo_q, div_lo_d;
  logic [HI_W-1:0]  div_hi_q, div_hi_d;

  // Ramp state
  logic [7:0]       cur_q [3];
  logic [7:0]       cur_d [3];
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pend_q, pend_d;
  rr_e              rr_q, rr_d;

  // Registered outputs
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             led_wr_en_q, led_wr_en_d;
  logic [4:0]       led_addr_q, led_addr_d;
  logic [7:0]       led_wr_data_q, led_wr_data_d;

  // Helpers
  logic [DIV_W-1:0] div;
  logic             div_wr;
  logic             tick;
  logic [2:0]       ramp_set;
  logic [2:0]       status;
  logic [8:0]       sum [3];
  logic [8:0]       dif [3];
  logic             found;
  logic [1:0]       sel;
  logic [7:0]       sel_cur;

  assign div    = {div_hi_q, div_lo_q};
  assign div_wr = wr_en && (addr == 5'd16 || addr == 5'd20);
  // A divider write in the cycle the count matches swallows that tick.
  assign tick   = (cnt_q == div) && !div_wr;

  // Prescaler: 0..DIV, restarted by any divider write.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (div_wr || cnt_q == div) begin
      cnt_d = '0;
    end
  end

  // Ramp engine. Arithmetic is 9 bits wide so that a rising sum above 255
  // and a falling difference below 0 are both detectable and clamp to TGT.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      sum[i]      = {1'b0, cur_q[i]} + {1'b0, step_q};
      dif[i]      = {1'b0, cur_q[i]} - {1'b0, step_q};
      cur_d[i]    = cur_q[i];
      if (tick && cur_q[i] != tgt_q[i]) begin
        if (step_q == '0) begin
          cur_d[i] = tgt_q[i];
        end else if (cur_q[i] < tgt_q[i]) begin
          cur_d[i] = (sum[i] >= {1'b0, tgt_q[i]}) ? tgt_q[i] : sum[i][7:0];
        end else begin
          cur_d[i] = (dif[i][8] || dif[i][7:0] <= tgt_q[i]) ? tgt_q[i] : dif[i][7:0];
        end
      end
      ramp_set[i] = (cur_d[i] != cur_q[i]);
      status[i]   = (cur_q[i] != tgt_q[i]);
    end
  end

  // Writer selection: first pending channel at or after the pointer.
  always_comb begin
    found = |pend_q;
    sel   = 2'd0;
    unique case (rr_q)
      RR_CH1:  sel = pend_q[1] ? 2'd1 : (pend_q[2] ? 2'd2 : 2'd0);
      RR_CH2:  sel = pend_q[2] ? 2'd2 : (pend_q[0] ? 2'd0 : 2'd1);
      default: sel = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
    endcase

    unique case (sel)
      2'd1:    sel_cur = cur_q[1];
      2'd2:    sel_cur = cur_q[2];
      default: sel_cur = cur_q[0];
    endcase
  end

  // Writer next state. The issue clears the selected pending bit first and
  // the ramp sets bits afterwards, so a channel updated by a tick in the
  // very cycle it is being written stays pending and is written again with
  // its newer duty.
  always_comb begin
    pend_d        = pend_q;
    rr_d          = rr_q;
    led_wr_en_d   = 1'b0;
    led_addr_d    = '0;
    led_wr_data_d = '0;
    if (found) begin
      pend_d[sel]   = 1'b0;
      led_wr_en_d   = 1'b1;
      led_addr_d    = {1'b0, sel, 2'b00};
      led_wr_data_d = sel_cur;
      unique case (sel)
        2'd0:    rr_d = RR_CH1;
        2'd1:    rr_d = RR_CH2;
        default: rr_d = RR_CH0;
      endcase
    end
    pend_d = pend_d | ramp_set;
  end

  // CPU register writes. New values land after the edge, so a tick on the
  // same edge still sees the previous TGT/STEP.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      tgt_d[i] = tgt_q[i];
    end
    step_d   = step_q;
    div_lo_d = div_lo_q;
    div_hi_d = div_hi_q;
    if (wr_en) begin
      unique case (addr)
        5'd0:    tgt_d[0] = wr_data;
        5'd4:    tgt_d[1] = wr_data;
        5'd8:    tgt_d[2] = wr_data;
        5'd12:   step_d   = wr_data;
        5'd16:   div_lo_d = wr_data;
        5'd20:   div_hi_d = wr_data[HI_W-1:0];
        default: ;
      endcase
    end
  end

  // CPU reads: registered, from pre-edge state.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = '0;
    if (rd_en) begin
      unique case (addr)
        5'd0:    rd_data_d = tgt_q[0];
        5'd4:    rd_data_d = tgt_q[1];
        5'd8:    rd_data_d = tgt_q[2];
        5'd12:   rd_data_d = step_q;
        5'd16:   rd_data_d = div_lo_q;
        5'd20:   rd_data_d = 8'(div_hi_q);
        5'd24:   rd_data_d = {5'b0, status};
        5'd28:   rd_data_d = cur_q[0];
        5'd29:   rd_data_d = cur_q[1];
        5'd30:   rd_data_d = cur_q[2];
        default: rd_data_d = '0;
      endcase
    end
  end

  // All pending bits come up set, so leaving reset rewrites 0 to every led
  // channel on three consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q         <= '{default: '0};
      step_q        <= '0;
      div_lo_q      <= '0;
      div_hi_q      <= '0;
      cur_q         <= '{default: '0};
      cnt_q         <= '0;
      pend_q        <= 3'b111;
      rr_q          <= RR_CH0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      led_wr_en_q   <= 1'b0;
      led_addr_q    <= '0;
      led_wr_data_q <= '0;
    end else begin
      tgt_q         <= tgt_d;
      step_q        <= step_d;
      div_lo_q      <= div_lo_d;
      div_hi_q      <= div_hi_d;
      cur_q         <= cur_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      rr_q          <= rr_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      led_wr_en_q   <= led_wr_en_d;
      led_addr_q    <= led_addr_d;
      led_wr_data_q <= led_wr_data_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign led_wr_en   = led_wr_en_q;
  assign led_addr    = led_addr_q;
  assign led_wr_data = led_wr_data_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: directed scenarios followed by random
// CPU traffic, all checked cycle by cycle against a behavioural model.
module tb_led_fader;

  localparam int unsigned DIV_W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       led_wr_en;
  logic [4:0] led_addr;
  logic [7:0] led_wr_data;

  led_fader #(.DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .addr        (addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .led_wr_en   (led_wr_en),
    .led_addr    (led_addr),
    .led_wr_data (led_wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Behavioural model state
  int m_tgt [3];
  int m_cur [3];
  bit m_pend [3];
  int m_step, m_lo, m_hi, m_cnt, m_rr;
  int e_wr_en, e_addr, e_wdata, e_rv, e_rd;

  // Observed led writes
  int lg_addr [$];
  int lg_data [$];
  int lg_cyc  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_div();
    return m_hi * 256 + m_lo;
  endfunction

  function automatic int regval(input int a);
    case (a)
      0:  return m_tgt[0];
      4:  return m_tgt[1];
      8:  return m_tgt[2];
      12: return m_step;
      16: return m_lo;
      20: return m_hi;
      24: return ((m_cur[0] != m_tgt[0]) ? 1 : 0) + ((m_cur[1] != m_tgt[1]) ? 2 : 0)
               + ((m_cur[2] != m_tgt[2]) ? 4 : 0);
      28: return m_cur[0];
      29: return m_cur[1];
      30: return m_cur[2];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_tgt[i]  = 0;
      m_cur[i]  = 0;
      m_pend[i] = 1'b1;
    end
    m_step = 0; m_lo = 0; m_hi = 0; m_cnt = 0; m_rr = 0;
    e_wr_en = 0; e_addr = 0; e_wdata = 0; e_rv = 0; e_rd = 0;
  endtask

  // One clock edge of the model, all decisions taken from pre-edge state.
  task automatic model_update();
    int a, d, nv, c;
    bit dwr, tick;
    a    = int'(addr);
    d    = int'(wr_data);
    dwr  = wr_en && (a == 16 || a == 20);
    tick = (m_cnt == m_div()) && !dwr;

    e_rv = rd_en ? 1 : 0;
    if (rd_en) e_rd = regval(a);

    e_wr_en = 0;
    for (int k = 0; k < 3; k++) begin
      c = (m_rr + k) % 3;
      if (e_wr_en == 0 && m_pend[c]) begin
        e_wr_en   = 1;
        e_addr    = 4 * c;
        e_wdata   = m_cur[c];
        m_pend[c] = 1'b0;
        m_rr      = (c + 1) % 3;
      end
    end

    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (m_cur[i] != m_tgt[i]) begin
          if (m_step == 0)              nv = m_tgt[i];
          else if (m_cur[i] < m_tgt[i]) nv = (m_cur[i] + m_step > m_tgt[i]) ? m_tgt[i] : m_cur[i] + m_step;
          else                          nv = (m_cur[i] - m_step < m_tgt[i]) ? m_tgt[i] : m_cur[i] - m_step;
          if (nv != m_cur[i]) m_pend[i] = 1'b1;
          m_cur[i] = nv;
        end
      end
    end

    if (dwr || m_cnt == m_div()) m_cnt = 0;
    else                         m_cnt = m_cnt + 1;

    if (wr_en) begin
      case (a)
        0:  m_tgt[0] = d;
        4:  m_tgt[1] = d;
        8:  m_tgt[2] = d;
        12: m_step   = d;
        16: m_lo     = d;
        20: m_hi     = d & ((1 << (DIV_W - 8)) - 1);
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("led_wr_en", led_wr_en, e_wr_en);
    if (e_wr_en != 0) begin
      chk("led_addr", led_addr, e_addr);
      chk("led_wr_data", led_wr_data, e_wdata);
    end
    chk("rd_valid", rd_valid, e_rv);
    if (e_rv != 0) chk("rd_data", rd_data, e_rd);
    if (led_wr_en === 1'b1) begin
      lg_addr.push_back(int'(led_addr));
      lg_data.push_back(int'(led_wr_data));
      lg_cyc.push_back(cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_update();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    lg_addr.delete();
    lg_data.delete();
    lg_cyc.delete();
  endtask

  task automatic cpu_wr(input int a, input int d);
    wr_en   = 1'b1;
    addr    = 5'(a);
    wr_data = 8'(d);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic cpu_rd_chk(input string tag, input int a, input int expv);
    rd_en = 1'b1;
    addr  = 5'(a);
    step();
    rd_en = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, expv);
  endtask

  task automatic chk_log(input string tag, input int idx, input int a, input int d);
    if (idx < lg_addr.size()) begin
      chk($sformatf("%s_addr%0d", tag, idx), lg_addr[idx], a);
      chk($sformatf("%s_data%0d", tag, idx), lg_data[idx], d);
    end else begin
      chk($sformatf("%s_missing%0d", tag, idx), lg_addr.size(), idx + 1);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, held over one edge, then released.
  task automatic async_reset_pulse();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("areset_led_wr_en", led_wr_en, 0);
    chk("areset_led_addr", led_addr, 0);
    chk("areset_led_wr_data", led_wr_data, 0);
    chk("areset_rd_valid", rd_valid, 0);
    chk("areset_rd_data", rd_data, 0);
    step();
    rst = 1'b0;
  endtask

  task automatic chk_resync(input string tag);
    chk({tag, "_count"}, lg_addr.size(), 3);
    chk_log(tag, 0, 0, 0);
    chk_log(tag, 1, 4, 0);
    chk_log(tag, 2, 8, 0);
    if (lg_cyc.size() == 3) chk({tag, "_span"}, lg_cyc[2] - lg_cyc[0], 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    int r;
    int a;
    model_reset();

    // Power-on reset and resync writes
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    clear_log();
    run(6);
    chk_resync("por_sync");
    cpu_rd_chk("por_status", 24, 0);

    // Rising ramp with saturation at DIV=0
    cpu_wr(12, 10);
    clear_log();
    cpu_wr(0, 25);
    cpu_rd_chk("rise_status_busy", 24, 1);
    run(6);
    chk("rise_count", lg_addr.size(), 3);
    chk_log("rise", 0, 0, 10);
    chk_log("rise", 1, 0, 20);
    chk_log("rise", 2, 0, 25);
    cpu_rd_chk("rise_status_done", 24, 0);
    cpu_rd_chk("rise_cur0", 28, 25);

    // Falling ramp from 250 at DIV=3
    cpu_wr(12, 0);
    cpu_wr(4, 250);
    run(4);
    cpu_wr(16, 3);
    cpu_wr(12, 100);
    clear_log();
    cpu_wr(4, 3);
    run(20);
    chk("fall_count", lg_addr.size(), 3);
    chk_log("fall", 0, 4, 150);
    chk_log("fall", 1, 4, 50);
    chk_log("fall", 2, 4, 3);
    if (lg_cyc.size() == 3) begin
      chk("fall_gap0", lg_cyc[1] - lg_cyc[0], 4);
      chk("fall_gap1", lg_cyc[2] - lg_cyc[1], 4);
    end

    // Instant jump
    cpu_wr(12, 0);
    clear_log();
    cpu_wr(8, 200);
    run(10);
    chk("jump_count", lg_addr.size(), 1);
    chk_log("jump", 0, 8, 200);

    // Round-robin: three channels change on the same tick
    cpu_wr(16, 9);
    cpu_wr(12, 255);
    clear_log();
    cpu_wr(0, 1);
    cpu_wr(4, 2);
    cpu_wr(8, 3);
    run(12);
    chk("rr_count", lg_addr.size(), 3);
    chk_log("rr", 0, 0, 1);
    chk_log("rr", 1, 4, 2);
    chk_log("rr", 2, 8, 3);
    if (lg_cyc.size() == 3) chk("rr_span", lg_cyc[2] - lg_cyc[0], 2);

    // TGT0 write on the tick edge only takes effect on the following tick
    guard = 0;
    while (m_cnt != m_div() && guard < 50) begin
      step();
      guard++;
    end
    chk("collide_wait", (guard < 50) ? 1 : 0, 1);
    clear_log();
    cpu_wr(0, 50);
    run(5);
    chk("collide_none", lg_addr.size(), 0);
    run(8);
    chk("collide_count", lg_addr.size(), 1);
    chk_log("collide", 0, 0, 50);

    // Readback, back-to-back reads, read concurrent with write
    cpu_wr(20, 'h12);
    cpu_wr(16, 'h34);
    cpu_wr(12, 7);
    cpu_rd_chk("rb_step", 12, 7);
    cpu_rd_chk("rb_div_lo", 16, 'h34);
    cpu_rd_chk("rb_div_hi", 20, 'h12);
    cpu_rd_chk("rb_status", 24, 0);
    cpu_rd_chk("rb_unmapped", 31, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 5'(28 + i);
      step();
    end
    wr_en   = 1'b1;
    addr    = 5'd12;
    wr_data = 8'd9;
    step();
    wr_en = 1'b0;
    chk("rb_same_cycle_old", rd_data, 7);
    step();
    rd_en = 1'b0;
    chk("rb_same_cycle_new", rd_data, 9);
    step();
    chk("rb_valid_drop", rd_valid, 0);

    // Reset in the middle of a ramp
    cpu_wr(20, 0);
    cpu_wr(16, 0);
    cpu_wr(12, 3);
    cpu_wr(0, 200);
    run(5);
    clear_log();
    async_reset_pulse();
    run(6);
    chk_resync("mid_sync");
    cpu_rd_chk("mid_status", 24, 0);
    cpu_rd_chk("mid_cur0", 28, 0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 4 * r;
      else if (r == 8) a = $urandom_range(29, 31);
      else             a = $urandom_range(0, 31);
      addr  = 5'(a);
      wr_en = ($urandom_range(0, 3) == 0);
      rd_en = $urandom_range(0, 1) != 0;
      if (a == 16)      wr_data = 8'($urandom_range(0, 4));
      else if (a == 20) wr_data = 8'd0;
      else if (a == 12) wr_data = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
      else              wr_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
      else                             step();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
